// File: rtl/instr_pkg.sv
// Shared encoding constants, error codes, state type and field packing for the instruction
// encoder; the bit positions match the datapath decoder.
package instr_pkg;

    localparam logic [2:0] OPC_B    = 3'b001;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MEM     = 2'b00;
    localparam logic [1:0] OP_B       = 2'b00;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_FULL    = 2'b11;

    localparam int unsigned OPC_LSB = 13;
    localparam int unsigned OP_LSB  = 11;
    localparam int unsigned RN_LSB  = 8;
    localparam int unsigned RD_LSB  = 5;
    localparam int unsigned SH_LSB  = 3;
    localparam int unsigned RM_LSB  = 0;

    localparam logic [15:0] HALT_WORD = 16'hE000;

    typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERR} state_t;

    // Immediate formats reuse the rd/shift/rm slots for their low bits.
    function automatic logic [15:0] pack_fields(input logic [2:0] opc, input logic [1:0] op,
                                                input logic [2:0] rn, input logic [2:0] rd,
                                                input logic [1:0] sh, input logic [2:0] rm);
        return (16'(opc) << OPC_LSB) | (16'(op) << OP_LSB) | (16'(rn) << RN_LSB) |
               (16'(rd) << RD_LSB) | (16'(sh) << SH_LSB) | (16'(rm) << RM_LSB);
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational field-to-word packer. Immediate range checking is built only when
// INSTR_ENCODER_RANGE_CHECK_EN is defined; otherwise immediates are truncated.
module instr_field_packer
    import instr_pkg::*;
(
    input  logic [2:0]  i_opcode,
    input  logic [1:0]  i_op,
    input  logic [2:0]  i_rn,
    input  logic [2:0]  i_rd,
    input  logic [2:0]  i_rm,
    input  logic [1:0]  i_shift,
    input  logic [15:0] i_imm,
    output logic [15:0] o_word,
    output logic        o_illegal,
    output logic        o_range_err
);

    logic w_need_imm8;
    logic w_need_imm5;

    always_comb begin
        o_word      = '0;
        o_illegal   = 1'b0;
        w_need_imm8 = 1'b0;
        w_need_imm5 = 1'b0;
        case (i_opcode)
            OPC_MOV: begin
                if (i_op == OP_MOV_IMM) begin
                    o_word      = pack_fields(OPC_MOV, OP_MOV_IMM, i_rn,
                                              i_imm[7:5], i_imm[4:3], i_imm[2:0]);
                    w_need_imm8 = 1'b1;
                end else if (i_op == OP_MOV_REG) begin
                    o_word = pack_fields(OPC_MOV, OP_MOV_REG, 3'b000, i_rd, i_shift, i_rm);
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OPC_ALU: begin
                o_word = pack_fields(OPC_ALU, i_op,
                                     (i_op == OP_MVN) ? 3'b000 : i_rn,
                                     (i_op == OP_CMP) ? 3'b000 : i_rd,
                                     i_shift, i_rm);
            end
            OPC_LDR, OPC_STR: begin
                if (i_op == OP_MEM) begin
                    o_word      = pack_fields(i_opcode, OP_MEM, i_rn, i_rd,
                                              i_imm[4:3], i_imm[2:0]);
                    w_need_imm5 = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OPC_B: begin
                if (i_op == OP_B) begin
                    o_word      = pack_fields(OPC_B, OP_B, i_rn,
                                              i_imm[7:5], i_imm[4:3], i_imm[2:0]);
                    w_need_imm8 = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OPC_HALT: o_word = HALT_WORD;
            default:  o_illegal = 1'b1;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic w_fits_imm8;
    logic w_fits_imm5;

    // A value fits when every bit above the field's sign bit copies that sign bit.
    assign w_fits_imm8 = (i_imm[15:7] == 9'h000) || (i_imm[15:7] == 9'h1FF);
    assign w_fits_imm5 = (i_imm[15:4] == 12'h000) || (i_imm[15:4] == 12'hFFF);
    assign o_range_err = (w_need_imm8 && !w_fits_imm8) || (w_need_imm5 && !w_fits_imm5);
`else
    logic w_unused_range;

    assign w_unused_range = ^{i_imm[15:8], w_need_imm8, w_need_imm5};
    assign o_range_err    = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts field bundles over valid/ready, packs them and writes the words
// sequentially from BASE_ADDR. Optional range checking via INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [1:0]        in_op,
    input  logic [2:0]        in_rn,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rm,
    input  logic [1:0]        in_shift,
    input  logic [15:0]       in_imm,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [15:0]       r_wdata, w_wdata_next;
    logic [ADDR_W:0]   r_count, w_count_next;
    logic              r_done, w_done_next;
    logic              r_err, w_err_next;
    logic [1:0]        r_code, w_code_next;

    logic [15:0]       w_word;
    logic              w_illegal;
    logic              w_range_err;

    instr_field_packer u_packer (
        .i_opcode    (in_opcode),
        .i_op        (in_op),
        .i_rn        (in_rn),
        .i_rd        (in_rd),
        .i_rm        (in_rm),
        .i_shift     (in_shift),
        .i_imm       (in_imm),
        .o_word      (w_word),
        .o_illegal   (w_illegal),
        .o_range_err (w_range_err)
    );

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_count_next = r_count;
        w_done_next  = r_done;
        w_err_next   = r_err;
        w_code_next  = r_code;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    w_state_next = ACCEPT;
                    w_addr_next  = BASE;
                    w_count_next = '0;
                    w_done_next  = 1'b0;
                    w_err_next   = 1'b0;
                    w_code_next  = ERR_NONE;
                end
            end
            ACCEPT: begin
                if (in_valid) begin
                    if (w_illegal) begin
                        w_state_next = ERR;
                        w_err_next   = 1'b1;
                        w_code_next  = ERR_ILLEGAL;
                    end else if (w_range_err) begin
                        w_state_next = ERR;
                        w_err_next   = 1'b1;
                        w_code_next  = ERR_RANGE;
                    end else begin
                        w_state_next = WRITE;
                        w_wdata_next = w_word;
                    end
                end
            end
            WRITE: begin
                w_count_next = r_count + {{ADDR_W{1'b0}}, 1'b1};
                // Only HALT packs to this value, so the registered word identifies it.
                if (r_wdata == HALT_WORD) begin
                    w_state_next = DONE;
                    w_done_next  = 1'b1;
                end else if (&r_addr) begin
                    w_state_next = ERR;
                    w_err_next   = 1'b1;
                    w_code_next  = ERR_FULL;
                end else begin
                    w_state_next = ACCEPT;
                    w_addr_next  = r_addr + ADDR_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= BASE;
            r_wdata <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_count <= w_count_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_code  <= w_code_next;
        end
    end

    assign in_ready   = (r_state == ACCEPT);
    assign mem_write  = (r_state == WRITE);
    assign busy       = (r_state == ACCEPT) || (r_state == WRITE);
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign done       = r_done;
    assign err        = r_err;
    assign err_code   = r_code;
    assign word_count = r_count;

endmodule
